keypad_scan: RTL and testbench
==============================

# keypad_scan

Scans a 4x4 matrix keypad (PmodKYPD layout) for the keyStop design and emits one debounced hex key code per press. It consumes the scan strobe derived from the `clkdiv` output: a one-`clk`-wide `tick` that paces column stepping and debouncing. It drives the keypad column lines, reads the row lines, and feeds `key_code`/`key_valid` to the stopwatch control logic downstream.

## Interface
- `DEBOUNCE_SCANS`, default 4: consecutive identical `tick` samples required to accept a press or a release. Legal range 2..255.
- `REPEAT_SCANS`, default 64: ticks between auto-repeat pulses. Used only with `KEYPAD_REPEAT_EN`.
- `clk` input 1: system clock.
- `clr` input 1: reset, asynchronous, active-high.
- `tick` input 1: scan strobe, one `clk` wide. Continuous high is legal (simulation speed-up).
- `row` input 4: keypad rows, active-low, pulled up externally, asynchronous to `clk`.
- `col` output 4: keypad columns, active-low, exactly one bit low at all times.
- `key_code` output 4: hex value of the last accepted key. Held until the next accept.
- `key_valid` output 1: one-`clk` pulse when a key is accepted.
- `key_down` output 1: high while a debounced key is held.

## Operation
- `row` passes through a 2-flop synchronizer. All decisions use the synchronized `row_s`.
- Key map (column, row → code):
  - col0: 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
  - Row 0 is the top row.
- States are SCAN, DEBOUNCE, HELD, RELEASE. All state transitions and counter updates occur only on `clk` edges where `tick` is 1.
- SCAN:
  - If `row_s` is all ones, advance the column: `col` rotates 1110→1101→1011→0111→1110.
  - Otherwise, latch the lowest-index low row as `hit_row` and the current column, clear `cnt`, and go to DEBOUNCE. `col` is frozen.
- DEBOUNCE:
  - If `row_s[hit_row]` is 0, increment `cnt`.
  - When the sample that makes `DEBOUNCE_SCANS` consecutive hits is taken: load `key_code`, pulse `key_valid`, set `key_down`, and go to HELD.
  - If `row_s[hit_row]` is 1, go to SCAN and advance the column.
- HELD:
  - If `row_s[hit_row]` is 1, clear `cnt` and go to RELEASE.
  - Other rows going low are ignored.
- RELEASE:
  - If `row_s[hit_row]` is 1, increment `cnt`. After `DEBOUNCE_SCANS` consecutive highs, clear `key_down` and go to SCAN with the column advanced.
  - If `row_s[hit_row]` is 0, return to HELD with no new `key_valid`.
- `cnt` is 8 bits and saturates; it never wraps.
- Simultaneous presses: only the lowest-index low row in the first column found is reported. No second key is reported until the held key is released.
- Reset values:
  - `col` = 1110
  - `key_code` = 0
  - `key_valid` = 0
  - `key_down` = 0
  - state = SCAN, `cnt` = 0
- `clr` mid-operation returns all of the above immediately and asynchronously. Any press in progress is discarded without a pulse.

## Timing
- `row` to `row_s` latency: 2 `clk` cycles.
- Column settle time: one `tick` period. `col` changes on a tick edge, and the new column's rows are sampled on the next tick.
- Press to `key_valid`: `key_valid` is high in the cycle after the tick edge of the `DEBOUNCE_SCANS`-th hit. Minimum is `DEBOUNCE_SCANS` ticks after the first sampled low. It deasserts on the following `clk` edge.
- `key_code` changes on the same edge that `key_valid` rises.
- `key_down` rises with `key_valid` and falls on the tick edge of the `DEBOUNCE_SCANS`-th consecutive release sample.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a separate repeat counter counts ticks.
  - Every `REPEAT_SCANS` ticks, `key_valid` pulses again with the unchanged `key_code`.
  - The repeat counter clears on entry to HELD and on leaving it.
- `KEYPAD_REPEAT_EN` undefined: exactly one `key_valid` per press. No repeat counter is synthesized.

## Structure
- `keypad_pkg` holds:
  - the state enum (SCAN, DEBOUNCE, HELD, RELEASE)
  - the `KEY_MAP` 16-entry constant indexed {col, row}
  - the column reset constant 4'b1110
- Sub-module `sync2` is a 2-flop synchronizer, 4 bits wide, with async `clr` to 1s (idle level).

## Test plan
- Reset: assert `clr` with `tick` running → `col`=1110, `key_valid`=0, `key_down`=0, `key_code`=0. Columns rotate with period 4 ticks after release.
- Clean press of key 5 (row1 low while col=1101) for 10 ticks, `DEBOUNCE_SCANS`=4 → exactly one `key_valid`, `key_code`=5, `key_down` high until 4 ticks after release.
- Bounce: row low 2 ticks, high 1, low 2, then released → no `key_valid`, state returns to SCAN.
- Rows 1 and 3 low in col3 → `key_code`=B.
- Release glitch: 2 high ticks, then low again → no second pulse, `key_down` stays 1.
- Hold for 200 ticks:
  - Without `KEYPAD_REPEAT_EN` → 1 pulse.
  - With `KEYPAD_REPEAT_EN` and `REPEAT_SCANS`=64 → 4 pulses.
  - `clr` pulsed mid-DEBOUNCE → immediate reset values and no pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the 4x4 keypad scanner
//               (scan states, key map, column reset pattern).
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] c_COL_RESET = 4'b1110;

    // Nibble {col,row} holds the hex code; index 0 is the LSB nibble.
    // col0: 1,4,7,0  col1: 2,5,8,F  col2: 3,6,9,E  col3: A,B,C,D
    localparam logic [63:0] c_KEY_MAP = 64'hDCBA_E963_F852_0741;

    function automatic logic [3:0] key_lookup(input logic [1:0] c, input logic [1:0] r);
        logic [5:0] base;
        base = {c, r, 2'b00};
        return c_KEY_MAP[base +: 4];
    endfunction

    // Index of the lowest-numbered zero bit (active-low lines).
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : 4-bit two-flop synchronizer for the keypad row lines,
//               resets to the idle (all ones) level.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 matrix keypad scanner with debounce; one key_valid pulse
//               per accepted press. Optional auto-repeat: KEYPAD_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 255 || REPEAT_SCANS < 1) begin : g_param_check
        $error("keypad_scan: parameter out of range");
    end

    localparam logic [7:0] c_DEB_LAST = 8'(DEBOUNCE_SCANS - 1);

    state_t     state_q, state_d;
    logic [3:0] col_q, col_d;
    logic [1:0] hit_row_q, hit_row_d;
    logic [1:0] hit_col_q, hit_col_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       down_q, down_d;

    logic [3:0] row_s;
    logic [3:0] w_col_next;
    logic [7:0] w_cnt_inc;
    logic       w_hit_high;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] c_REP_LAST = 16'(REPEAT_SCANS - 1);
    logic [15:0] rep_q, rep_d;
`endif

    sync2 u_sync (
        .clk (clk),
        .clr (clr),
        .d_i (row),
        .q_o (row_s)
    );

    assign w_col_next = {col_q[2:0], col_q[3]};
    assign w_cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign w_hit_high = row_s[hit_row_q];

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        hit_row_d = hit_row_q;
        hit_col_d = hit_col_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        down_d    = down_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d     = (state_q == ST_HELD) ? rep_q : 16'd0;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (&row_s) begin
                        col_d = w_col_next;
                    end else begin
                        hit_row_d = low_index(row_s);
                        hit_col_d = low_index(col_q);
                        cnt_d     = 8'd0;
                        state_d   = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_hit_high) begin
                        state_d = ST_SCAN;
                        col_d   = w_col_next;
                    end else if (cnt_q == c_DEB_LAST) begin
                        cnt_d   = w_cnt_inc;
                        code_d  = key_lookup(hit_col_q, hit_row_q);
                        valid_d = 1'b1;
                        down_d  = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (w_hit_high) begin
                        cnt_d   = 8'd0;
                        state_d = ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = 16'd0;
                    end else if (rep_q == c_REP_LAST) begin
                        rep_d   = 16'd0;
                        valid_d = 1'b1;
                    end else begin
                        rep_d   = rep_q + 16'd1;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (!w_hit_high) begin
                        state_d = ST_HELD;
                    end else if (cnt_q == c_DEB_LAST) begin
                        cnt_d   = w_cnt_inc;
                        down_d  = 1'b0;
                        state_d = ST_SCAN;
                        col_d   = w_col_next;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_SCAN;
            col_q     <= c_COL_RESET;
            hit_row_q <= 2'd0;
            hit_col_q <= 2'd0;
            cnt_q     <= 8'd0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            hit_row_q <= hit_row_d;
            hit_col_q <= hit_col_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            down_q    <= down_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rep_q <= 16'd0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign col       = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan
// Description : Self-checking bench for keypad_scan with a behavioural 4x4
//               key matrix; honours KEYPAD_REPEAT_EN for the hold test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = 16'h0000;
    logic [1:0]  tick_div = 2'd0;

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    int p0;

`ifdef KEYPAD_REPEAT_EN
    localparam int c_HOLD_PULSES = 4;
`else
    localparam int c_HOLD_PULSES = 1;
`endif

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  code;
    } vec_t;

    vec_t vecs [8];

    keypad_scan #(
        .DEBOUNCE_SCANS (4),
        .REPEAT_SCANS   (64)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .tick      (tick),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // One-clk tick every 4 clocks, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            tick_div = tick_div + 2'd1;
            tick     = (tick_div == 2'd0);
        end
    end

    // Key matrix: pressed bit {c,r} pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col[c] && pressed[c*4 + r]) row[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_wait();
        do @(posedge clk); while (!tick);
        #1;
    endtask

    task automatic align_col(input logic [3:0] target);
        for (int i = 0; i < 8; i++) begin
            tick_wait();
            if (col == target) break;
        end
        check("align col", int'(col), int'(target));
    endtask

    task automatic wait_valid(input string name, input int max_ticks);
        int t;
        t = 0;
        while (!key_valid && t < max_ticks) begin
            tick_wait();
            t++;
        end
        check({name, " key_valid"}, int'(key_valid), 1);
    endtask

    initial begin
        vecs[0] = '{16'h0020, 4'h5};
        vecs[1] = '{16'h0001, 4'h1};
        vecs[2] = '{16'h0008, 4'h0};
        vecs[3] = '{16'h0080, 4'hF};
        vecs[4] = '{16'h0800, 4'hE};
        vecs[5] = '{16'hA000, 4'hB};
        vecs[6] = '{16'h0400, 4'h9};
        vecs[7] = '{16'h1000, 4'hA};

        // Reset with tick running
        repeat (3) tick_wait();
        check("rst col", int'(col), 4'b1110);
        check("rst key_code", int'(key_code), 0);
        check("rst key_valid", int'(key_valid), 0);
        check("rst key_down", int'(key_down), 0);
        @(negedge clk);
        clr = 1'b0;
        tick_wait();
        check("rot col1", int'(col), 4'b1101);
        tick_wait();
        check("rot col2", int'(col), 4'b1011);
        tick_wait();
        check("rot col3", int'(col), 4'b0111);
        tick_wait();
        check("rot col4", int'(col), 4'b1110);

        // Exact latency of key 5 pressed while col0 is active
        align_col(4'b1110);
        p0 = pulse_cnt;
        pressed = 16'h0020;
        repeat (5) tick_wait();
        check("lat no early valid", int'(key_valid), 0);
        check("lat col frozen", int'(col), 4'b1101);
        tick_wait();
        check("lat key_valid", int'(key_valid), 1);
        check("lat key_code", int'(key_code), 4'h5);
        check("lat key_down", int'(key_down), 1);
        @(posedge clk);
        #1;
        check("lat pulse width", int'(key_valid), 0);
        repeat (4) tick_wait();
        pressed = 16'h0000;
        repeat (4) tick_wait();
        check("lat down hold", int'(key_down), 1);
        tick_wait();
        check("lat down fall", int'(key_down), 0);
        check("lat pulses", pulse_cnt - p0, 1);

        // Table of single and simultaneous presses
        for (int i = 0; i < 8; i++) begin
            p0 = pulse_cnt;
            pressed = vecs[i].mask;
            wait_valid("vec", 40);
            check("vec code", int'(key_code), int'(vecs[i].code));
            check("vec down", int'(key_down), 1);
            repeat (5) tick_wait();
            pressed = 16'h0000;
            repeat (4) tick_wait();
            check("vec down hold", int'(key_down), 1);
            tick_wait();
            check("vec down fall", int'(key_down), 0);
            check("vec pulses", pulse_cnt - p0, 1);
            check("vec code held", int'(key_code), int'(vecs[i].code));
            repeat (2) tick_wait();
        end

        // Bounce: two lows then a high abort the debounce
        align_col(4'b1110);
        p0 = pulse_cnt;
        pressed = 16'h0020;
        repeat (3) tick_wait();
        check("bounce col frozen", int'(col), 4'b1101);
        pressed = 16'h0000;
        tick_wait();
        check("bounce back to scan", int'(col), 4'b1011);
        pressed = 16'h0020;
        repeat (2) tick_wait();
        pressed = 16'h0000;
        repeat (8) tick_wait();
        check("bounce pulses", pulse_cnt - p0, 0);
        check("bounce key_down", int'(key_down), 0);

        // Release glitch: two high samples, then low again
        p0 = pulse_cnt;
        pressed = 16'h0020;
        wait_valid("glitch", 40);
        repeat (2) tick_wait();
        pressed = 16'h0000;
        repeat (2) tick_wait();
        pressed = 16'h0020;
        repeat (6) tick_wait();
        check("glitch key_down", int'(key_down), 1);
        check("glitch pulses", pulse_cnt - p0, 1);
        pressed = 16'h0000;
        repeat (5) tick_wait();
        check("glitch down fall", int'(key_down), 0);

        // Long hold
        p0 = pulse_cnt;
        pressed = 16'h0020;
        wait_valid("hold", 40);
        repeat (200) tick_wait();
        check("hold pulses", pulse_cnt - p0, c_HOLD_PULSES);
        check("hold key_down", int'(key_down), 1);
        pressed = 16'h0000;
        repeat (6) tick_wait();
        check("hold down fall", int'(key_down), 0);

        // Asynchronous clear in the middle of a debounce
        align_col(4'b1110);
        pressed = 16'h0020;
        repeat (3) tick_wait();
        p0 = pulse_cnt;
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr col", int'(col), 4'b1110);
        check("clr key_code", int'(key_code), 0);
        check("clr key_down", int'(key_down), 0);
        check("clr key_valid", int'(key_valid), 0);
        pressed = 16'h0000;
        @(negedge clk);
        clr = 1'b0;
        repeat (10) tick_wait();
        check("clr pulses", pulse_cnt - p0, 0);
        check("clr key_down after", int'(key_down), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
